dct_row_split: RTL
==================

DCT_ROW_SPLIT -- requirements
Module: dct_row_split

Interface
REQ-001 SHALL have parameter DW, default 28, signed lane width.
REQ-002 SHALL have parameter LANES, default 32, lanes per row.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_valid, input, 1, upstream row valid.
REQ-006 SHALL have port i_start, input, 1, the current row is the first row of a block.
REQ-007 SHALL have port i_size, input, 2, block rows: 0=4, 1=8, 2=16, 3=32; sampled with i_start.
REQ-008 SHALL have port i_sel, input, 1, destination channel; sampled with i_start.
REQ-009 SHALL have port i_data, input, LANES*DW, row data, lane k at bits [k*DW +: DW].
REQ-010 SHALL have port o_ready, output, 1, upstream row accepted when i_valid && o_ready.
REQ-011 SHALL have ports o_0_valid / o_1_valid, output, 1 each, channel row valid.
REQ-012 SHALL have ports o_0_data / o_1_data, output, LANES*DW each, channel row data.
REQ-013 SHALL have ports o_0_last / o_1_last, output, 1 each, final row of the block.
REQ-014 SHALL have ports i_0_ready / i_1_ready, input, 1 each, channel consumer ready.
REQ-015 SHALL have port o_busy, output, 1, high while in state RUN.
REQ-016 SHALL have port o_err, output, 1, one-cycle protocol-error pulse.

Function
REQ-017 SHALL implement a state machine with states IDLE and RUN, a row counter cnt[4:0], and latched sel_q and size_q.
REQ-018 SHALL use sel_eff = i_sel in IDLE and sel_q in RUN.
REQ-019 SHALL use N = 4 << size_eff, where size_eff = i_size in IDLE and size_q in RUN.
REQ-020 SHALL drive o_ready = !rst && (!o_x_valid || i_x_ready), with x = sel_eff, as a combinational signal.
REQ-021 SHALL, for an accepted row, load that row into channel sel_eff's output register on the next edge, giving 1-cycle latency and a throughput of 1 row/cycle.
REQ-022 SHALL clear a channel register when o_x_valid && i_x_ready with no simultaneous load.
REQ-023 SHALL give load priority when drain and load coincide, so valid stays 1 and the data is replaced.
REQ-024 SHALL hold o_x_data and o_x_last stable while o_x_valid && !i_x_ready.
REQ-025 SHALL leave the unselected channel's register untouched by any accept.
REQ-026 SHALL, in IDLE, on an accepted row with i_start=1: latch sel_q and size_q, set cnt=1, and go to RUN.
REQ-027 SHALL, in IDLE, on an accepted row with i_start=0: drop the row, load no channel, pulse o_err, and stay in IDLE.
REQ-028 SHALL, in RUN, on an accepted row with i_start=0: route it to sel_q and increment cnt.
REQ-029 SHALL, in RUN, when the accepted row has cnt==N-1: set o_x_last=1 for that row, clear cnt, and go to IDLE.
REQ-030 SHALL, in RUN, on an accepted row with i_start=1: pulse o_err, abort the old block (no last is emitted for it), and restart per REQ-026 using the new i_sel and i_size.
REQ-031 SHALL accept back-to-back blocks, with a start row in the cycle immediately after a last row, and no bubble.
REQ-032 SHALL ignore i_start, i_size, i_sel and i_data whenever i_valid=0.

Reset
REQ-033 SHALL, when rst=1 at an edge, set state=IDLE, cnt=0, sel_q=0, size_q=0, all o_x_valid/o_x_last=0, o_x_data=0, and o_err=0.
REQ-034 SHALL hold o_ready=0 while rst=1, and discard any in-flight rows or partial blocks.

Structure
REQ-035 SHALL take DW, LANES, the size encoding and the IDLE/RUN state enum from shared package tq_pkg.
REQ-036 SHALL implement each channel register as sub-module dct_row_slot (load, drain, data, last), instantiated twice.

Verification
REQ-037 SHALL test an 8-row block (start, size=1, sel=0) with i_0_ready=1: o_0_valid for 8 consecutive cycles, one cycle after each input; last on row 8; o_1_valid stays 0.
REQ-038 SHALL test 32-row block to sel=1 followed immediately by 4-row block to sel=0: no gap; o_1_last on row 32, then o_0 rows 1-4 with last on row 4.
REQ-039 SHALL test i_1_ready=0 for 3 cycles mid-block on sel=1: o_ready=0 after 1 buffered row; o_1_data held; resumes with no loss or duplication.
REQ-040 SHALL test a row without start in IDLE: o_err 1-cycle pulse, no channel valid, state stays IDLE.
REQ-041 SHALL test i_start at row 3 of a 16-row block: o_err pulse, no last for the old block, new block counted from 1.
REQ-042 SHALL test rst asserted mid-block at row 5: all outputs 0 next cycle; a subsequent start row is accepted normally.

Source files
------------

// File: rtl/tq_pkg.sv
// Shared types and constants for the DCT row splitter.
package tq_pkg;

   localparam int TQ_DW    = 28;
   localparam int TQ_LANES = 32;

   // Block height encoding carried on i_size
   typedef enum logic [1:0] {
      SZ_4  = 2'd0,
      SZ_8  = 2'd1,
      SZ_16 = 2'd2,
      SZ_32 = 2'd3
   } size_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Number of rows in a block of the given size (4, 8, 16 or 32)
   function automatic logic [5:0] rows_of(size_e s);
      return 6'd4 << s;
   endfunction

endpackage

// File: rtl/dct_row_split_if.sv
// One output channel of the row splitter: valid/ready handshake with row data and block-last flag.
interface dct_row_split_if #(
   parameter int W = tq_pkg::TQ_DW * tq_pkg::TQ_LANES
);
   logic         valid;
   logic         ready;
   logic         last;
   logic [W-1:0] data;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/dct_row_slot.sv
// Single-entry output register for one channel: load wins over drain, holds while stalled.
module dct_row_slot
   import tq_pkg::*;
#(
   parameter int W = TQ_DW * TQ_LANES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         last_i,
   dct_row_split_if.master ch
);

   logic         valid_q;
   logic         last_q;
   logic [W-1:0] data_q;

   // Load a new row, or empty the slot once the consumer has taken it
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         last_q  <= last_i;
         data_q  <= data_i;
      end else if (valid_q && ch.ready) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end
   end

   assign ch.valid = valid_q;
   assign ch.last  = last_q;
   assign ch.data  = data_q;

endmodule

// File: rtl/dct_row_split.sv
// Routes rows of a DCT block to one of two channels, counting rows and flagging the block's last row.
module dct_row_split
   import tq_pkg::*;
#(
   parameter int DW    = TQ_DW,
   parameter int LANES = TQ_LANES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic                i_start,
   input  logic [1:0]          i_size,
   input  logic                i_sel,
   input  logic [LANES*DW-1:0] i_data,
   output logic                o_ready,
   output logic                o_0_valid,
   output logic [LANES*DW-1:0] o_0_data,
   output logic                o_0_last,
   input  logic                i_0_ready,
   output logic                o_1_valid,
   output logic [LANES*DW-1:0] o_1_data,
   output logic                o_1_last,
   input  logic                i_1_ready,
   output logic                o_busy,
   output logic                o_err
);

   localparam int W = LANES * DW;

   state_e     state_q;
   logic [4:0] cnt_q;
   logic       sel_q;
   size_e      size_q;
   logic       err_q;

   logic       sel_eff;
   size_e      size_eff;
   logic [5:0] n_eff;
   logic       accept;
   logic       at_last;
   logic       load_sel;
   logic [1:0] load_d;

   logic [1:0]        ch_valid;
   logic [1:0]        ch_ready;
   logic [1:0]        ch_last;
   logic [1:0][W-1:0] ch_data;

   // While idle the incoming start row decides channel and size; inside a block the latched values do
   assign sel_eff  = (state_q == RUN) ? sel_q  : i_sel;
   assign size_eff = (state_q == RUN) ? size_q : size_e'(i_size);
   assign n_eff    = rows_of(size_eff);

   assign o_ready = !rst && (!ch_valid[sel_eff] || ch_ready[sel_eff]);
   assign accept  = i_valid && o_ready;
   assign at_last = (state_q == RUN) && !i_start && ({1'b0, cnt_q} == n_eff - 6'd1);

   // A start row always opens a block on its own i_sel, including a restart inside a running block
   assign load_sel = i_start ? i_sel : sel_q;

   // Pick the channel that captures the accepted row; stray rows in IDLE load nothing
   always_comb begin
      load_d = 2'b00;
      if (accept && (state_q == RUN || i_start)) begin
         load_d[load_sel] = 1'b1;
      end
   end

   // Block sequencer: row counter, latched routing, and the error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         sel_q   <= 1'b0;
         size_q  <= SZ_4;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (accept) begin
            if (i_start) begin
               // A start inside a block abandons the old one without a last row
               err_q   <= (state_q == RUN);
               sel_q   <= i_sel;
               size_q  <= size_e'(i_size);
               cnt_q   <= 5'd1;
               state_q <= RUN;
            end else if (state_q == IDLE) begin
               err_q <= 1'b1;
            end else if (at_last) begin
               cnt_q   <= 5'd0;
               state_q <= IDLE;
            end else begin
               cnt_q <= cnt_q + 5'd1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         dct_row_split_if #(.W(W)) ch ();

         dct_row_slot #(.W(W)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .load_i (load_d[gi]),
            .data_i (i_data),
            .last_i (at_last),
            .ch     (ch.master)
         );

         assign ch_valid[gi] = ch.valid;
         assign ch_last[gi]  = ch.last;
         assign ch_data[gi]  = ch.data;
         assign ch.ready     = ch_ready[gi];
      end
   endgenerate

   assign ch_ready  = {i_1_ready, i_0_ready};
   assign o_0_valid = ch_valid[0];
   assign o_0_data  = ch_data[0];
   assign o_0_last  = ch_last[0];
   assign o_1_valid = ch_valid[1];
   assign o_1_data  = ch_data[1];
   assign o_1_last  = ch_last[1];
   assign o_busy    = (state_q == RUN);
   assign o_err     = err_q;

endmodule
